// File: rtl/digit_mux_scanner.sv
// digit_mux_scanner: time-multiplexes two hex digits onto one seven-segment
// decoder nibble and drives the two active-low anode enables, with a
// programmable all-off gap between digits to suppress ghosting.
// Optional feature macro: DIGIT_MUX_LEAD_ZERO_BLANK_EN (blank a leading zero
// on digit 1).
module digit_mux_scanner #(
  parameter int unsigned PERIOD = 24000,
  parameter int unsigned BLANK  = 240,
  parameter int unsigned CW     = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  output logic [3:0] s,
  output logic [1:0] an,
  output logic       sel
);

  typedef enum logic [1:0] {
    DIG0   = 2'd0,
    BLANK0 = 2'd1,
    DIG1   = 2'd2,
    BLANK1 = 2'd3
  } state_t;

  // Last count value of each phase; a zero-length blank still needs one
  // cycle in BLANK1 after reset, so it is treated as length 1 there.
  localparam logic [CW-1:0] PER_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] BLK_LAST = (BLANK == 0) ? '0 : CW'(BLANK - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CW-1:0] last;
  logic [3:0]    s_nx;
  logic [1:0]    an_nx;
  logic          sel_nx;

  // State, phase counter and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= BLANK1;
      cnt   <= '0;
      an    <= 2'b11;
      s     <= '0;
      sel   <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      an    <= an_nx;
      s     <= s_nx;
      sel   <= sel_nx;
    end
  end

  // Next-state, counter and output values; outputs only change on phase entry
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    s_nx     = s;
    an_nx    = an;
    sel_nx   = sel;
    last     = (state == DIG0 || state == DIG1) ? PER_LAST : BLK_LAST;

    // ">=" also catches an out-of-range count and forces an advance
    if (cnt >= last) begin
      cnt_nx = '0;
      case (state)
        DIG0:    state_nx = (BLANK == 0) ? DIG1 : BLANK0;
        BLANK0:  state_nx = DIG1;
        DIG1:    state_nx = (BLANK == 0) ? DIG0 : BLANK1;
        BLANK1:  state_nx = DIG0;
        default: state_nx = BLANK1;
      endcase

      case (state_nx)
        DIG0: begin
          s_nx   = d0;
          sel_nx = 1'b0;
          an_nx  = 2'b10;
        end
        DIG1: begin
          s_nx   = d1;
          sel_nx = 1'b1;
`ifdef DIGIT_MUX_LEAD_ZERO_BLANK_EN
          an_nx  = (d1 == 4'h0) ? 2'b11 : 2'b01;
`else
          an_nx  = 2'b01;
`endif
        end
        default: an_nx = 2'b11;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_mux_scanner.sv
// Self-checking bench for digit_mux_scanner: one instance with a blanking gap
// (PERIOD=4, BLANK=2) and one without (PERIOD=4, BLANK=0), checked every
// cycle against a timeline model plus hand-computed literal expectations.
module tb_digit_mux_scanner;

  localparam int P = 4;
`ifdef DIGIT_MUX_LEAD_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] d0, d1;
  logic [3:0] s_a, s_b;
  logic [1:0] an_a, an_b;
  logic       sel_a, sel_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  digit_mux_scanner #(.PERIOD(4), .BLANK(2), .CW(4)) u0 (
    .clk(clk), .reset_n(reset_n), .d0(d0), .d1(d1),
    .s(s_a), .an(an_a), .sel(sel_a)
  );

  digit_mux_scanner #(.PERIOD(4), .BLANK(0), .CW(4)) u1 (
    .clk(clk), .reset_n(reset_n), .d0(d0), .d1(d1),
    .s(s_b), .an(an_b), .sel(sel_b)
  );

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // Timeline model: position since reset release decides the phase; digit
  // values are captured only on the cycle a digit phase begins.
  int         mk   [2];
  logic [3:0] ms   [2];
  logic [1:0] man  [2];
  logic       msel [2];
  logic       mlz  [2];
  bit         mvalid = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int b, b1, f, q;
      b  = (i == 0) ? 2 : 0;
      b1 = (b == 0) ? 1 : b;
      f  = 2 * (P + b);
      if (!reset_n) begin
        mk[i]   = 0;
        ms[i]   = 4'h0;
        msel[i] = 1'b1;
        man[i]  = 2'b11;
        mlz[i]  = 1'b0;
        mvalid  = 1'b1;
      end else if (mvalid) begin
        mk[i]++;
        if (mk[i] < b1) begin
          man[i] = 2'b11;
        end else begin
          q = (mk[i] - b1) % f;
          if (q < P) begin
            if (q == 0) begin ms[i] = d0; msel[i] = 1'b0; end
            man[i] = 2'b10;
          end else if (q < P + b) begin
            man[i] = 2'b11;
          end else if (q < 2 * P + b) begin
            if (q == P + b) begin
              ms[i] = d1; msel[i] = 1'b1; mlz[i] = LZ && (d1 == 4'h0);
            end
            man[i] = mlz[i] ? 2'b11 : 2'b01;
          end else begin
            man[i] = 2'b11;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (mvalid) begin
      chk("a_s",   {4'h0, s_a},   {4'h0, ms[0]});
      chk("a_an",  {6'h0, an_a},  {6'h0, man[0]});
      chk("a_sel", {7'h0, sel_a}, {7'h0, msel[0]});
      chk("a_an_not_00", {7'h0, (an_a != 2'b00)}, 8'h01);
      chk("b_s",   {4'h0, s_b},   {4'h0, ms[1]});
      chk("b_an",  {6'h0, an_b},  {6'h0, man[1]});
      chk("b_sel", {7'h0, sel_b}, {7'h0, msel[1]});
      chk("b_an_not_00", {7'h0, (an_b != 2'b00)}, 8'h01);
    end
  end

  initial begin
    d0 = 4'h3;
    d1 = 4'hA;
    reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_a_an",  {6'h0, an_a},  8'h03);
    chk("rst_a_s",   {4'h0, s_a},   8'h00);
    chk("rst_a_sel", {7'h0, sel_a}, 8'h01);
    chk("rst_b_an",  {6'h0, an_b},  8'h03);
    reset_n = 1'b1;

    for (int k = 1; k <= 33; k++) begin
      tick();
      if (k == 1) begin
        chk("start_a_blank", {6'h0, an_a}, 8'h03);
        chk("start_b_an",    {6'h0, an_b}, 8'h02);
        chk("start_b_s",     {4'h0, s_b},  8'h03);
      end
      if (k == 2) begin
        chk("dig0_a_an",  {6'h0, an_a},  8'h02);
        chk("dig0_a_s",   {4'h0, s_a},   8'h03);
        chk("dig0_a_sel", {7'h0, sel_a}, 8'h00);
      end
      if (k == 5) begin
        chk("dig0_a_last", {6'h0, an_a}, 8'h02);
        chk("dig1_b_an",   {6'h0, an_b}, 8'h01);
        chk("dig1_b_s",    {4'h0, s_b},  8'h0A);
      end
      if (k == 6) begin
        chk("blank0_a_an", {6'h0, an_a}, 8'h03);
        chk("blank0_a_s",  {4'h0, s_a},  8'h03);
      end
      if (k == 8) begin
        chk("dig1_a_an",  {6'h0, an_a},  8'h01);
        chk("dig1_a_s",   {4'h0, s_a},   8'h0A);
        chk("dig1_a_sel", {7'h0, sel_a}, 8'h01);
      end
      if (k == 12) begin
        chk("blank1_a_an", {6'h0, an_a}, 8'h03);
        chk("blank1_a_s",  {4'h0, s_a},  8'h0A);
      end
      if (k == 14) begin
        chk("frame2_a_an", {6'h0, an_a}, 8'h02);
        chk("frame2_a_s",  {4'h0, s_a},  8'h03);
      end
      if (k == 15) d0 = 4'h7;
      if (k == 19) chk("midchg_a_hold", {4'h0, s_a}, 8'h03);
      if (k == 26) begin
        chk("midchg_a_new", {4'h0, s_a},  8'h07);
        chk("frame3_a_an",  {6'h0, an_a}, 8'h02);
      end
    end

    // Reset pulse in the middle of a DIG1 phase
    reset_n = 1'b0;
    tick();
    chk("midrst_a_an",  {6'h0, an_a},  8'h03);
    chk("midrst_a_s",   {4'h0, s_a},   8'h00);
    chk("midrst_a_sel", {7'h0, sel_a}, 8'h01);
    reset_n = 1'b1;

    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) begin
        chk("replay_a_blank", {6'h0, an_a}, 8'h03);
        d0 = 4'h5;
        d1 = 4'h0;
      end
      if (k == 2) begin
        chk("replay_a_an", {6'h0, an_a}, 8'h02);
        chk("replay_a_s",  {4'h0, s_a},  8'h05);
      end
      if (k == 8) begin
        chk("zero_a_s",   {4'h0, s_a},   8'h00);
        chk("zero_a_sel", {7'h0, sel_a}, 8'h01);
        chk("zero_a_an",  {6'h0, an_a},  LZ ? 8'h03 : 8'h01);
      end
      if (k == 14) chk("zero_a_dig0", {6'h0, an_a}, 8'h02);
      if (k == 15) d1 = 4'h2;
      if (k == 20) begin
        chk("nz_a_an", {6'h0, an_a}, 8'h01);
        chk("nz_a_s",  {4'h0, s_a},  8'h02);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
